if_fetch_ctrl: RTL and testbench

- Sequencer for the instruction-fetch front end: PC register, PC+4 adder, 4:1 next-PC mux, instruction ROM and IF/ID latch.
- Each cycle it decides:
  - whether the PC register loads;
  - which next-PC source is selected;
  - whether IF/ID loads, is flushed to a bubble, or holds;
  - whether ID/EX receives a bubble.
- Handles boot, load-use stalls, branch/jump redirects, multi-cycle instruction memory and halt/resume.

---
 rtl/if_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front-end sequencer: drives PC load enable, next-PC
// select, IF/ID load/flush and ID/EX bubble for boot, load-use stalls,
// branch/jump redirects, multi-cycle instruction memory and halt/resume.
// Build option: define FETCH_PERF_EN to build the stall/redirect counters;
// otherwise stall_cnt and redir_cnt are tied to zero.
//
// state | meaning
// BOOT  | load reset vector into PC, bubble IF/ID and ID/EX
// RUN   | normal fetch; stall, redirect or halt decided here
// WAIT  | instruction memory busy for IMEM_LAT cycles, IF/ID gets bubbles
// HALT  | fetch frozen until resume pulse
module if_fetch_ctrl #(
   parameter int IMEM_LAT   = 0,
   parameter bit DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        load_dep,
   input  logic        br_taken,
   input  logic        is_jump,
   input  logic        halt_req,
   input  logic        resume,
   output logic        pc_we,
   output logic [1:0]  pcsource,
   output logic        ifid_we,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        fetch_valid,
   output logic        halted,
   output logic [15:0] stall_cnt,
   output logic [15:0] redir_cnt
);

   typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_t;

   localparam logic [3:0] LAT = 4'(IMEM_LAT);

   state_t     state;
   logic [3:0] wcnt;
   logic       redirect;
   logic       halt_go;

   // Output decode; reset forces the BOOT pattern regardless of the stale state.
   always_comb begin
      pc_we       = 1'b0;
      pcsource    = 2'b00;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      fetch_valid = 1'b0;
      halted      = 1'b0;
      redirect    = 1'b0;
      halt_go     = 1'b0;
      if (clrn || state == BOOT) begin
         pc_we       = 1'b1;
         pcsource    = 2'b11;
         ifid_we     = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               redirect = !load_dep && (br_taken || is_jump);
               if (load_dep) begin
                  idex_bubble = 1'b1;
               end else if (redirect) begin
                  pc_we       = 1'b1;
                  pcsource    = br_taken ? 2'b01 : 2'b10;
                  ifid_we     = 1'b1;
                  ifid_flush  = !DELAY_SLOT;
                  fetch_valid = DELAY_SLOT;
               end else if (halt_req) begin
                  // A halt that coincides with a redirect is picked up on the
                  // next RUN cycle because halt_req is a held level.
                  halt_go    = 1'b1;
                  ifid_we    = 1'b1;
                  ifid_flush = 1'b1;
               end else begin
                  pc_we       = 1'b1;
                  ifid_we     = 1'b1;
                  fetch_valid = 1'b1;
               end
            end
            WAIT: begin
               ifid_we    = 1'b1;
               ifid_flush = 1'b1;
            end
            HALT: begin
               idex_bubble = 1'b1;
               halted      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State and wait-counter update.
   always_ff @(posedge clk) begin
      if (clrn) begin
         state <= BOOT;
         wcnt  <= 4'd0;
      end else begin
         case (state)
            BOOT: begin
               if (LAT != 4'd0) begin
                  state <= WAIT;
                  wcnt  <= LAT;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (halt_go) begin
                  state <= HALT;
               end else if (pc_we && LAT != 4'd0) begin
                  state <= WAIT;
                  wcnt  <= LAT;
               end
            end
            WAIT: begin
               wcnt <= wcnt - 4'd1;
               // <= 1 also recovers from a zero count instead of wrapping.
               if (wcnt <= 4'd1) state <= RUN;
            end
            HALT: begin
               if (resume) state <= RUN;
            end
            default: state <= BOOT;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] stall_q;
   logic [15:0] redir_q;

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (clrn) begin
         stall_q <= 16'h0000;
         redir_q <= 16'h0000;
      end else begin
         if (state != BOOT && !fetch_valid && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (redirect && redir_q != 16'hFFFF)
            redir_q <= redir_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
   assign redir_cnt = redir_q;
`else
   assign stall_cnt = 16'h0000;
   assign redir_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with three instances:
// 0: IMEM_LAT=0 DELAY_SLOT=1, 1: IMEM_LAT=0 DELAY_SLOT=0, 2: IMEM_LAT=2 DELAY_SLOT=1.
// A small PC model follows instances 0 and 2.
module tb_if_fetch_ctrl;

`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [31:0] BPC = 32'h0000_0100;
   localparam logic [31:0] JPC = 32'h0000_0200;

   logic clk = 1'b0;
   logic clrn, load_dep, br_taken, is_jump, halt_req, resume;

   logic        pc_we       [3];
   logic [1:0]  pcsource    [3];
   logic        ifid_we     [3];
   logic        ifid_flush  [3];
   logic        idex_bubble [3];
   logic        fetch_valid [3];
   logic        halted      [3];
   logic [15:0] stall_cnt   [3];
   logic [15:0] redir_cnt   [3];

   logic [31:0] pc_a, pc_c;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   if_fetch_ctrl #(.IMEM_LAT(0), .DELAY_SLOT(1'b1)) u_a (
      .clk(clk), .clrn(clrn), .load_dep(load_dep), .br_taken(br_taken),
      .is_jump(is_jump), .halt_req(halt_req), .resume(resume),
      .pc_we(pc_we[0]), .pcsource(pcsource[0]), .ifid_we(ifid_we[0]),
      .ifid_flush(ifid_flush[0]), .idex_bubble(idex_bubble[0]),
      .fetch_valid(fetch_valid[0]), .halted(halted[0]),
      .stall_cnt(stall_cnt[0]), .redir_cnt(redir_cnt[0]));

   if_fetch_ctrl #(.IMEM_LAT(0), .DELAY_SLOT(1'b0)) u_b (
      .clk(clk), .clrn(clrn), .load_dep(load_dep), .br_taken(br_taken),
      .is_jump(is_jump), .halt_req(halt_req), .resume(resume),
      .pc_we(pc_we[1]), .pcsource(pcsource[1]), .ifid_we(ifid_we[1]),
      .ifid_flush(ifid_flush[1]), .idex_bubble(idex_bubble[1]),
      .fetch_valid(fetch_valid[1]), .halted(halted[1]),
      .stall_cnt(stall_cnt[1]), .redir_cnt(redir_cnt[1]));

   if_fetch_ctrl #(.IMEM_LAT(2), .DELAY_SLOT(1'b1)) u_c (
      .clk(clk), .clrn(clrn), .load_dep(load_dep), .br_taken(br_taken),
      .is_jump(is_jump), .halt_req(halt_req), .resume(resume),
      .pc_we(pc_we[2]), .pcsource(pcsource[2]), .ifid_we(ifid_we[2]),
      .ifid_flush(ifid_flush[2]), .idex_bubble(idex_bubble[2]),
      .fetch_valid(fetch_valid[2]), .halted(halted[2]),
      .stall_cnt(stall_cnt[2]), .redir_cnt(redir_cnt[2]));

   function automatic logic [31:0] npc(input logic [1:0] s, input logic [31:0] pc);
      case (s)
         2'b00:   return pc + 32'd4;
         2'b01:   return BPC;
         2'b10:   return JPC;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (pc_we[0]) pc_a <= npc(pcsource[0], pc_a);
      if (pc_we[2]) pc_c <= npc(pcsource[2], pc_c);
   end

   task automatic c1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic c2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic c16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic c32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change right after the falling edge; checks follow 1 time unit later.
   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      clrn = 1'b1; load_dep = 1'b0; br_taken = 1'b0; is_jump = 1'b0;
      halt_req = 1'b0; resume = 1'b0;

      // ---- reset held ----
      nxt(); #1;
      c1("rst_pc_we", pc_we[0], 1'b1);
      c2("rst_pcsource", pcsource[0], 2'b11);
      c1("rst_ifid_we", ifid_we[0], 1'b1);
      c1("rst_ifid_flush", ifid_flush[0], 1'b1);
      c1("rst_idex_bubble", idex_bubble[0], 1'b1);
      c1("rst_fetch_valid", fetch_valid[0], 1'b0);
      c1("rst_halted", halted[0], 1'b0);
      nxt();

      // ---- BOOT cycle after release ----
      nxt(); clrn = 1'b0; #1;
      c2("boot_pcsource", pcsource[0], 2'b11);
      c1("boot_pc_we", pc_we[0], 1'b1);
      c1("boot_ifid_flush", ifid_flush[0], 1'b1);
      c1("boot_fetch_valid", fetch_valid[0], 1'b0);
      c16("boot_stall_cnt", stall_cnt[0], 16'd0);

      // ---- three sequential fetches: PC 0,4,8 -> C ----
      nxt(); #1;
      c2("run1_pcsource", pcsource[0], 2'b00);
      c1("run1_fetch_valid", fetch_valid[0], 1'b1);
      c32("run1_pc", pc_a, 32'h0);
      nxt(); #1;
      c1("run2_fetch_valid", fetch_valid[0], 1'b1);
      c32("run2_pc", pc_a, 32'h4);
      nxt(); #1;
      c1("run3_fetch_valid", fetch_valid[0], 1'b1);
      c32("run3_pc", pc_a, 32'h8);

      // ---- one-cycle load-use stall ----
      nxt(); load_dep = 1'b1; #1;
      c1("ld_pc_we", pc_we[0], 1'b0);
      c1("ld_ifid_we", ifid_we[0], 1'b0);
      c1("ld_idex_bubble", idex_bubble[0], 1'b1);
      c1("ld_fetch_valid", fetch_valid[0], 1'b0);
      c32("ld_pc", pc_a, 32'hC);
      nxt(); load_dep = 1'b0; #1;
      c32("ld_pc_held", pc_a, 32'hC);
      c1("ld_after_pc_we", pc_we[0], 1'b1);
      c1("ld_after_idex_bubble", idex_bubble[0], 1'b0);

      // ---- branch and jump together: branch wins ----
      nxt(); br_taken = 1'b1; is_jump = 1'b1; #1;
      c32("br_pc_before", pc_a, 32'h10);
      c2("br_pcsource_ds1", pcsource[0], 2'b01);
      c1("br_flush_ds1", ifid_flush[0], 1'b0);
      c1("br_fv_ds1", fetch_valid[0], 1'b1);
      c16("br_redir_before", redir_cnt[0], 16'd0);
      c2("br_pcsource_ds0", pcsource[1], 2'b01);
      c1("br_flush_ds0", ifid_flush[1], 1'b1);
      c1("br_ifid_we_ds0", ifid_we[1], 1'b1);
      c1("br_fv_ds0", fetch_valid[1], 1'b0);

      // ---- load_dep with branch: stall only ----
      nxt(); is_jump = 1'b0; load_dep = 1'b1; #1;
      c32("br_pc_after", pc_a, BPC);
      c16("br_redir_after", redir_cnt[0], PERF ? 16'd1 : 16'd0);
      c1("ldbr_pc_we", pc_we[0], 1'b0);
      c1("ldbr_idex_bubble", idex_bubble[0], 1'b1);
      nxt(); load_dep = 1'b0; #1;
      c2("ldbr_pcsource", pcsource[0], 2'b01);
      c1("ldbr_pc_we_next", pc_we[0], 1'b1);

      // ---- jump only ----
      nxt(); br_taken = 1'b0; is_jump = 1'b1; #1;
      c16("jmp_redir_before", redir_cnt[0], PERF ? 16'd2 : 16'd0);
      c2("jmp_pcsource", pcsource[0], 2'b10);
      c1("jmp_fv", fetch_valid[0], 1'b1);

      // ---- halt request ----
      nxt(); is_jump = 1'b0; halt_req = 1'b1; #1;
      c32("jmp_pc_after", pc_a, JPC);
      c1("hreq_pc_we", pc_we[0], 1'b0);
      c1("hreq_ifid_flush", ifid_flush[0], 1'b1);
      c1("hreq_fv", fetch_valid[0], 1'b0);
      c1("hreq_halted", halted[0], 1'b0);
      nxt(); halt_req = 1'b0; #1;
      c1("halt_halted", halted[0], 1'b1);
      c1("halt_pc_we", pc_we[0], 1'b0);
      c1("halt_ifid_we", ifid_we[0], 1'b0);
      c1("halt_idex_bubble", idex_bubble[0], 1'b1);
      c32("halt_pc", pc_a, JPC);
      nxt(); resume = 1'b1; #1;
      c1("halt_still", halted[0], 1'b1);
      c32("halt_pc_frozen", pc_a, JPC);
      nxt(); resume = 1'b0; #1;
      c1("resume_halted", halted[0], 1'b0);
      c1("resume_fv", fetch_valid[0], 1'b1);
      c2("resume_pcsource", pcsource[0], 2'b00);
      c32("resume_pc", pc_a, JPC);
      c16("stall_cnt_a", stall_cnt[0], PERF ? 16'd5 : 16'd0);
      c16("redir_cnt_a", redir_cnt[0], PERF ? 16'd3 : 16'd0);
      nxt(); #1;
      c32("resume_pc_next", pc_a, JPC + 32'd4);

      // ---- IMEM_LAT=2 instance ----
      nxt(); clrn = 1'b1; #1;
      c2("lat_rst_pcsource", pcsource[2], 2'b11);
      nxt(); clrn = 1'b0; #1;
      c2("lat_boot_pcsource", pcsource[2], 2'b11);
      c1("lat_boot_pc_we", pc_we[2], 1'b1);
      nxt(); #1;
      c1("lat_w1_pc_we", pc_we[2], 1'b0);
      c1("lat_w1_flush", ifid_flush[2], 1'b1);
      c1("lat_w1_fv", fetch_valid[2], 1'b0);
      c1("lat_w1_idex_bubble", idex_bubble[2], 1'b0);
      nxt(); #1;
      c1("lat_w2_pc_we", pc_we[2], 1'b0);
      c1("lat_w2_flush", ifid_flush[2], 1'b1);
      nxt(); #1;
      c1("lat_r1_fv", fetch_valid[2], 1'b1);
      c1("lat_r1_pc_we", pc_we[2], 1'b1);
      c32("lat_r1_pc", pc_c, 32'h0);
      c16("lat_r1_stall", stall_cnt[2], PERF ? 16'd2 : 16'd0);
      nxt(); #1;
      c1("lat_w3_flush", ifid_flush[2], 1'b1);
      c1("lat_w3_fv", fetch_valid[2], 1'b0);
      c32("lat_w3_pc", pc_c, 32'h4);
      nxt(); #1;
      c1("lat_w4_flush", ifid_flush[2], 1'b1);
      nxt(); #1;
      c1("lat_r2_fv", fetch_valid[2], 1'b1);
      c32("lat_r2_pc", pc_c, 32'h4);
      c16("lat_r2_stall", stall_cnt[2], PERF ? 16'd4 : 16'd0);
      // reset in the middle of WAIT
      nxt(); clrn = 1'b1; #1;
      c2("lat_wrst_pcsource", pcsource[2], 2'b11);
      c1("lat_wrst_pc_we", pc_we[2], 1'b1);
      nxt(); clrn = 1'b0; #1;
      c2("lat_reboot_pcsource", pcsource[2], 2'b11);
      c1("lat_reboot_pc_we", pc_we[2], 1'b1);
      c1("lat_reboot_fv", fetch_valid[2], 1'b0);
      c16("lat_reboot_stall", stall_cnt[2], 16'd0);
      nxt(); #1;
      c1("lat_reboot_wait_pc_we", pc_we[2], 1'b0);
      c1("lat_reboot_wait_flush", ifid_flush[2], 1'b1);
      c32("lat_reboot_pc", pc_c, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
